// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// fetch_stage
// Instruction fetch for the 16-bit-instruction / 32-bit-datapath pipeline.
// Fetches 32-bit words from instruction memory, splits each into two
// halfword instructions, buffers them in a small FIFO and hands decode one
// instruction per cycle together with the PC of that instruction plus 4.
// Supports decode/load stalls, halfword-aligned branch redirects and a
// terminal halt on end of program.
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        stall_pc_i,
   input  logic        branch_i,
   input  logic [31:0] branch_target_i,
   input  logic        end_program_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_valid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [15:0] instr_o,
   output logic        instr_en_o,
   output logic [31:0] next_programm_counter_o,
   output logic        halt_o
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_W  = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [CNT_W:0] MIN_FREE = (CNT_W + 1)'(2);

   // RUN: idle, WAIT: one request outstanding, HALT: terminal until reset.
   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   logic [1:0]       state, state_n;
   logic [15:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr, wr_ptr_nx1;
   logic [CNT_W-1:0] count;
   logic [31:0]      fetch_pc;   // next word address to request
   logic [31:0]      head_pc;    // address of the instruction at the FIFO head
   logic [31:0]      req_addr;
   logic             skip_low;   // next kept word starts at its high halfword
   logic             discard;    // outstanding response belongs to a flushed path
   logic             req_q;

   logic             is_halt, branch_act, rsp, rsp_keep, pop, issue;
   logic [1:0]       push_cnt;
   logic [CNT_W:0]   free_after_pop;
   logic             unused_ok;

   assign is_halt    = (state == ST_HALT);
   assign branch_act = branch_i & ~is_halt;

   // Decode sees nothing in a redirect cycle: the FIFO is being flushed.
   assign instr_en_o = (count != '0) & ~is_halt & ~branch_i;
   assign instr_o    = instr_en_o ? fifo_mem[rd_ptr] : 16'hFFFF;
   assign pop        = instr_en_o & ~stall_i & ~stall_pc_i;

   // A response is only meaningful while waiting; RUN and HALT ignore it.
   assign rsp      = (state == ST_WAIT) & imem_valid_i;
   assign rsp_keep = rsp & ~discard & ~branch_i;
   assign push_cnt = rsp_keep ? (skip_low ? 2'd1 : 2'd2) : 2'd0;

   // Requesting only with two free slots guarantees room for a whole word.
   assign free_after_pop = DEPTH_W - {1'b0, count} + {{CNT_W{1'b0}}, pop};
   assign issue = (state == ST_RUN) & ~branch_i & ~end_program_i &
                  (free_after_pop >= MIN_FREE);

   assign wr_ptr_nx1 = wr_ptr + PTR_W'(1);

   assign imem_req_o              = req_q;
   assign imem_addr_o             = req_addr;
   assign next_programm_counter_o = head_pc + 32'd4;
   assign halt_o                  = is_halt;

   // Branch targets are halfword aligned, so bit 0 carries no information.
   assign unused_ok = &{1'b0, branch_target_i[0]};

   // Next-state selection: redirect beats end of program beats normal flow.
   always_comb begin
      // NOTE: default every always_comb output first so no path infers a latch.
      state_n = state;
      case (state)
         ST_RUN: begin
            if (branch_i)           state_n = ST_RUN;
            else if (end_program_i) state_n = ST_HALT;
            else if (issue)         state_n = ST_WAIT;
         end
         ST_WAIT: begin
            if (branch_i)           state_n = imem_valid_i ? ST_RUN : ST_WAIT;
            else if (end_program_i) state_n = ST_HALT;
            else if (imem_valid_i)  state_n = ST_RUN;
         end
         default: state_n = ST_HALT;
      endcase
   end

   // Control state, fetch/head program counters and FIFO pointers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst_i) begin
         state    <= ST_RUN;
         fetch_pc <= {RESET_PC[31:2], 2'b00};
         skip_low <= RESET_PC[1];
         head_pc  <= {RESET_PC[31:1], 1'b0};
         discard  <= 1'b0;
         req_q    <= 1'b0;
         req_addr <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         state <= state_n;
         req_q <= issue;
         if (issue) req_addr <= fetch_pc;

         if (branch_act) begin
            fetch_pc <= {branch_target_i[31:2], 2'b00};
            skip_low <= branch_target_i[1];
            head_pc  <= {branch_target_i[31:1], 1'b0};
            // A response landing in this very cycle is simply dropped; one
            // still in flight must be dropped when it arrives.
            discard  <= (state == ST_WAIT) & ~imem_valid_i;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
         end else begin
            if (rsp) discard <= 1'b0;
            if (rsp_keep) begin
               fetch_pc <= fetch_pc + 32'd4;
               skip_low <= 1'b0;
            end
            if (pop) head_pc <= head_pc + 32'd2;
            rd_ptr <= rd_ptr + PTR_W'(pop);
            wr_ptr <= wr_ptr + PTR_W'(push_cnt);
            count  <= count + CNT_W'(push_cnt) - CNT_W'(pop);
         end
      end
   end

   // Halfword storage; a word writes one or two consecutive entries.
   always_ff @(posedge clk_i) begin
      // NOTE: the storage array has no reset; the occupancy count alone
      // decides which entries are meaningful.
      if (push_cnt != 2'd0)
         fifo_mem[wr_ptr] <= skip_low ? imem_rdata_i[31:16] : imem_rdata_i[15:0];
      if (push_cnt == 2'd2)
         fifo_mem[wr_ptr_nx1] <= imem_rdata_i[31:16];
   end

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
// tb_fetch_stage
// Self-checking bench for fetch_stage. A behavioural model tracks which
// halfword address decode should see next and how far ahead memory has been
// fetched; FIFO occupancy follows from their difference. Instruction memory
// is a pure function of address, answered with fixed or random latency.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 4;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        stall_i = 1'b0, stall_pc_i = 1'b0, branch_i = 1'b0, end_program_i = 1'b0;
   logic [31:0] branch_target_i = '0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_valid_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic [15:0] instr_o;
   logic        instr_en_o;
   logic [31:0] next_programm_counter_o;
   logic        halt_o;

   always #5 clk_i = ~clk_i;

   fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i                   (clk_i),
      .rst_i                   (rst_i),
      .stall_i                 (stall_i),
      .stall_pc_i              (stall_pc_i),
      .branch_i                (branch_i),
      .branch_target_i         (branch_target_i),
      .end_program_i           (end_program_i),
      .imem_req_o              (imem_req_o),
      .imem_addr_o             (imem_addr_o),
      .imem_valid_i            (imem_valid_i),
      .imem_rdata_i            (imem_rdata_i),
      .instr_o                 (instr_o),
      .instr_en_o              (instr_en_o),
      .next_programm_counter_o (next_programm_counter_o),
      .halt_o                  (halt_o)
   );

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, wanted %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- instruction memory contents ----------------
   function automatic logic [15:0] hw(input logic [31:0] a);
      logic [31:0] i;
      i = a >> 1;
      if (i == 32'd0) return 16'h1000;
      return 16'h2000 ^ i[15:0] ^ i[30:15];
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {hw(a + 32'd2), hw(a)};
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          stale;
   } rsp_t;

   rsp_t        pend[$];   // requests seen, waiting for their response
   logic [31:0] m_head;    // halfword address decode should see next
   logic [31:0] m_want;    // word address following everything fetched so far
   bit          m_halted;
   bit          m_exp_req;
   int          lat_fixed; // 0 selects random latency 1..4

   function automatic int m_occ();
      logic [31:0] d;
      d = m_want - m_head;
      return int'($signed(d) >>> 1);
   endfunction

   function automatic int lat();
      if (lat_fixed > 0) return lat_fixed;
      return int'($urandom_range(1, 4));
   endfunction

   task automatic model_reset();
      m_head    = {RESET_PC[31:1], 1'b0};
      m_want    = {RESET_PC[31:2], 2'b00};
      m_halted  = 1'b0;
      m_exp_req = 1'b0;
      pend.delete();
      cyc = 0;
   endtask

   // One clock cycle: drive inputs at the falling edge, check outputs 1 ns
   // later, then advance the model with this cycle's events.
   task automatic step(input bit stall, input bit stall_pc, input bit br,
                       input logic [31:0] tgt, input bit endp);
      bit   rsp_valid, en_exp, pop, run;
      int   occ, used, free;
      rsp_t nr;
      @(negedge clk_i);
      rsp_valid       = (pend.size() > 0) && (pend[0].due == cyc);
      stall_i         = stall;
      stall_pc_i      = stall_pc;
      branch_i        = br;
      branch_target_i = tgt;
      end_program_i   = endp;
      imem_valid_i    = rsp_valid;
      imem_rdata_i    = rsp_valid ? mem_word(pend[0].addr) : 32'hDEAD_BEEF;
      #1;
      occ    = m_occ();
      used   = (occ > 0) ? occ : 0;
      en_exp = !m_halted && !br && (used > 0);
      check("halt", 32'(halt_o), 32'(m_halted));
      check("instr_en", 32'(instr_en_o), 32'(en_exp));
      check("instr", 32'(instr_o), en_exp ? 32'(hw(m_head)) : 32'h0000_FFFF);
      check("next_pc", next_programm_counter_o, m_head + 32'd4);
      check("imem_req", 32'(imem_req_o), 32'(m_exp_req));
      if (imem_req_o) begin
         check("one_outstanding", 32'(pend.size()), 32'd0);
         check("imem_addr", imem_addr_o, m_want);
      end

      pop = en_exp && !stall && !stall_pc;
      run = !m_halted && (pend.size() == 0) && !imem_req_o;
      if (imem_req_o) begin
         nr.addr  = imem_addr_o;
         nr.due   = cyc + lat();
         nr.stale = 1'b0;
         pend.push_back(nr);
      end
      if (pop) m_head = m_head + 32'd2;
      if (br && !m_halted) begin
         m_head = {tgt[31:1], 1'b0};
         m_want = {tgt[31:2], 2'b00};
         foreach (pend[i]) pend[i].stale = 1'b1;
      end
      if (rsp_valid) begin
         if (!pend[0].stale && !m_halted) m_want = m_want + 32'd4;
         void'(pend.pop_front());
      end
      free      = DEPTH - (used - (pop ? 1 : 0));
      m_exp_req = run && !br && !endp && (free >= 2);
      if (endp && !br) m_halted = 1'b1;
      cyc++;
   endtask

   task automatic idle_inputs();
      stall_i = 1'b0; stall_pc_i = 1'b0; branch_i = 1'b0; end_program_i = 1'b0;
      branch_target_i = '0; imem_valid_i = 1'b0; imem_rdata_i = '0;
   endtask

   // Release reset between clock edges so the next falling edge is cycle 0.
   task automatic release_reset();
      @(posedge clk_i);
      #2;
      rst_i = 1'b1;
      model_reset();
   endtask

   task automatic apply_reset();
      @(negedge clk_i);
      idle_inputs();
      rst_i = 1'b0;
      #1;
      check("rst_req", 32'(imem_req_o), 32'd0);
      check("rst_en", 32'(instr_en_o), 32'd0);
      check("rst_instr", 32'(instr_o), 32'h0000_FFFF);
      check("rst_next_pc", next_programm_counter_o, {RESET_PC[31:1], 1'b0} + 32'd4);
      check("rst_halt", 32'(halt_o), 32'd0);
      release_reset();
   endtask

   // ---------------- directed table: basic fetch and decode stall ----------------
   typedef struct {
      bit          stall;
      bit          exp_en;
      logic [15:0] exp_instr;
      logic [31:0] exp_npc;
      bit          exp_req;
      logic [31:0] exp_addr;
   } vec_t;

   vec_t tbl[14];

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bit seen;
      bit started;
      bit bubble;
      bit req_seen;

      tbl[0]  = '{1'b0, 1'b0, 16'hFFFF, 32'd4,  1'b0, 32'd0};
      tbl[1]  = '{1'b0, 1'b0, 16'hFFFF, 32'd4,  1'b1, 32'd0};
      tbl[2]  = '{1'b0, 1'b0, 16'hFFFF, 32'd4,  1'b0, 32'd0};
      tbl[3]  = '{1'b0, 1'b1, 16'h1000, 32'd4,  1'b0, 32'd0};
      tbl[4]  = '{1'b1, 1'b1, 16'h2001, 32'd6,  1'b1, 32'd4};
      tbl[5]  = '{1'b1, 1'b1, 16'h2001, 32'd6,  1'b0, 32'd0};
      tbl[6]  = '{1'b1, 1'b1, 16'h2001, 32'd6,  1'b0, 32'd0};
      tbl[7]  = '{1'b1, 1'b1, 16'h2001, 32'd6,  1'b0, 32'd0};
      tbl[8]  = '{1'b1, 1'b1, 16'h2001, 32'd6,  1'b0, 32'd0};
      tbl[9]  = '{1'b0, 1'b1, 16'h2001, 32'd6,  1'b0, 32'd0};
      tbl[10] = '{1'b0, 1'b1, 16'h2002, 32'd8,  1'b1, 32'd8};
      tbl[11] = '{1'b0, 1'b1, 16'h2003, 32'd10, 1'b0, 32'd0};
      tbl[12] = '{1'b0, 1'b1, 16'h2004, 32'd12, 1'b0, 32'd0};
      tbl[13] = '{1'b0, 1'b1, 16'h2005, 32'd14, 1'b1, 32'd12};

      // Basic fetch with latency 1, then a 5-cycle decode stall on 0x2001.
      lat_fixed = 1;
      apply_reset();
      for (int i = 0; i < 14; i++) begin
         step(tbl[i].stall, 1'b0, 1'b0, 32'd0, 1'b0);
         check("t1_en", 32'(instr_en_o), 32'(tbl[i].exp_en));
         check("t1_instr", 32'(instr_o), 32'(tbl[i].exp_instr));
         check("t1_next_pc", next_programm_counter_o, tbl[i].exp_npc);
         check("t1_req", 32'(imem_req_o), 32'(tbl[i].exp_req));
         if (tbl[i].exp_req) check("t1_addr", imem_addr_o, tbl[i].exp_addr);
      end

      // Redirect to 0x102 while a request is outstanding (latency 3).
      lat_fixed = 3;
      apply_reset();
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 32'h0000_0102, 1'b0);
      check("t3_branch_en", 32'(instr_en_o), 32'd0);
      seen = 1'b0;
      for (int k = 0; k < 12 && !seen; k++) begin
         step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
         seen = imem_req_o;
      end
      check("t3_req_seen", 32'(seen), 32'd1);
      check("t3_addr", imem_addr_o, 32'h0000_0100);
      seen = 1'b0;
      for (int k = 0; k < 12 && !seen; k++) begin
         step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
         seen = instr_en_o;
      end
      check("t3_en_seen", 32'(seen), 32'd1);
      check("t3_instr", 32'(instr_o), 32'h0000_2081);
      check("t3_next_pc", next_programm_counter_o, 32'h0000_0106);

      // Redirect in the same cycle the response arrives (latency 1).
      lat_fixed = 1;
      apply_reset();
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      check("t4_req_gap", 32'(imem_req_o), 32'd0);
      check("t4_en_empty", 32'(instr_en_o), 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      check("t4_req", 32'(imem_req_o), 32'd1);
      check("t4_addr", imem_addr_o, 32'h0000_0200);

      // Latency 3 with decode never stalling: bubbles must appear.
      lat_fixed = 3;
      apply_reset();
      started = 1'b0;
      bubble  = 1'b0;
      for (int k = 0; k < 40; k++) begin
         step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
         if (started && !instr_en_o) bubble = 1'b1;
         if (instr_en_o) started = 1'b1;
      end
      check("t5_bubble", 32'(bubble), 32'd1);

      // End of program with three instructions buffered, then async reset.
      lat_fixed = 1;
      apply_reset();
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
      check("t6_pre_en", 32'(instr_en_o), 32'd1);
      check("t6_pre_instr", 32'(instr_o), 32'h0000_2001);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      check("t6_halt", 32'(halt_o), 32'd1);
      check("t6_en", 32'(instr_en_o), 32'd0);
      req_seen = imem_req_o;
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b0, (k == 1), 32'h0000_0040, 1'b0);
         req_seen = req_seen | imem_req_o;
      end
      check("t6_no_req", 32'(req_seen), 32'd0);
      idle_inputs();
      #2;
      rst_i = 1'b0;
      #1;
      check("t6_async_halt", 32'(halt_o), 32'd0);
      check("t6_async_en", 32'(instr_en_o), 32'd0);
      check("t6_async_next_pc", next_programm_counter_o, {RESET_PC[31:1], 1'b0} + 32'd4);
      release_reset();
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      check("t6_restart_req", 32'(imem_req_o), 32'd1);
      check("t6_restart_addr", imem_addr_o, {RESET_PC[31:2], 2'b00});

      // Randomised traffic: stalls, redirects (some near address wrap) and
      // random memory latency, finishing with end of program.
      lat_fixed = 0;
      apply_reset();
      for (int k = 0; k < 3000; k++) begin
         bit          s, sp, b;
         logic [31:0] t;
         s  = ($urandom_range(0, 3) == 0);
         sp = ($urandom_range(0, 9) == 0);
         b  = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 3) == 0)
            t = 32'hFFFF_FFE0 + (32'($urandom_range(0, 15)) << 1);
         else
            t = 32'($urandom_range(0, 1023)) << 1;
         step(s, sp, b, t, 1'b0);
      end
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      check("rand_halt", 32'(halt_o), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
